dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe.sv | 89 ++++++++
 tb/tb_dff_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage enabled register pipeline. Each stage holds a WIDTH-bit
// data word and a valid flag; count is a registered popcount of the valid flags.
// Optional build macro DFF_PIPE_RESET_DATA_EN: when defined, rst also clears
// every data register to 0. When undefined, only the valid flags and count are
// reset, and the data registers keep their prior contents (or X after power-up).
module dff_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [CW-1:0]    count_nxt;

    // Next valid vector: flush clears everything, en shifts, otherwise hold.
    always_comb begin
        valid_nxt = valid;
        if (flush) begin
            valid_nxt = '0;
        end else if (en) begin
            valid_nxt[0] = in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                valid_nxt[k] = valid[k-1];
            end
        end
    end

    // Population count of the next valid vector, so count tracks the flags edge for edge.
    always_comb begin
        count_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_nxt = count_nxt + CW'(valid_nxt[k]);
        end
    end

    // Valid flags and occupancy count; rst overrides flush and en.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            count <= '0;
        end else begin
            valid <= valid_nxt;
            count <= count_nxt;
        end
    end

`ifdef DFF_PIPE_RESET_DATA_EN
    // Data shift register, cleared by rst; flush does not touch data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else if (en) begin
            data[0] <= in;
            for (int k = 1; k < DEPTH; k++) begin
                data[k] <= data[k-1];
            end
        end
    end
`else
    // Data shift register without reset; flush does not touch data.
    always_ff @(posedge clk) begin
        if (en) begin
            data[0] <= in;
            for (int k = 1; k < DEPTH; k++) begin
                data[k] <= data[k-1];
            end
        end
    end
`endif

    assign out       = data[DEPTH-1];
    assign out_valid = valid[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: three instances (8x4, 1x1, 8x3) sharing clock,
// reset and control; expected values are hand-computed per cycle.
module tb_dff_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic [7:0] in;
    logic [0:0] in1;
    logic       in_valid;

    logic [7:0] out4;
    logic       ov4;
    logic [2:0] cnt4;
    logic [0:0] out1;
    logic       ov1;
    logic [0:0] cnt1;
    logic [7:0] out3;
    logic       ov3;
    logic [1:0] cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    dff_pipe #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in(in), .in_valid(in_valid),
        .out(out4), .out_valid(ov4), .count(cnt4)
    );

    dff_pipe #(.WIDTH(1), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in(in1), .in_valid(in_valid),
        .out(out1), .out_valid(ov1), .count(cnt1)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in(in), .in_valid(in_valid),
        .out(out3), .out_valid(ov3), .count(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in = 8'h00; in1 = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // One cycle on the 8x4 instance: drive, clock, then check count/out_valid/out.
    task automatic cyc4(input string tag, input logic e, input logic f, input logic v,
                        input logic [7:0] d, input int ec, input logic eov, input logic [7:0] eo);
        en = e; flush = f; in_valid = v; in = d;
        step();
        check({tag, "_cnt"}, 32'(cnt4), 32'(ec));
        check({tag, "_ov"}, 32'(ov4), 32'(eov));
        if (eov) check({tag, "_out"}, 32'(out4), 32'(eo));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; flush = 1'b0; in = 8'h00; in1 = 1'b0; in_valid = 1'b0;

        // Reset state
        do_reset();
        check("rst_cnt4", 32'(cnt4), 0);
        check("rst_ov4", 32'(ov4), 0);
        check("rst_cnt1", 32'(cnt1), 0);
        check("rst_cnt3", 32'(cnt3), 0);

        // Basic latency: three items, out on cycles 5-7, count peaks at 3
        cyc4("lat1", 1, 0, 1, 8'h11, 1, 0, 8'h00);
        cyc4("lat2", 1, 0, 1, 8'h22, 2, 0, 8'h00);
        cyc4("lat3", 1, 0, 1, 8'h33, 3, 0, 8'h00);
        cyc4("lat4", 1, 0, 0, 8'h00, 3, 1, 8'h11);
        cyc4("lat5", 1, 0, 0, 8'h00, 2, 1, 8'h22);
        cyc4("lat6", 1, 0, 0, 8'h00, 1, 1, 8'h33);
        cyc4("lat7", 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // Two-cycle stall after 0x22 enters: 0x22 emerges two cycles later
        do_reset();
        cyc4("st1", 1, 0, 1, 8'h11, 1, 0, 8'h00);
        cyc4("st2", 1, 0, 1, 8'h22, 2, 0, 8'h00);
        cyc4("st3", 0, 0, 1, 8'h99, 2, 0, 8'h00);
        cyc4("st4", 0, 0, 1, 8'h99, 2, 0, 8'h00);
        cyc4("st5", 1, 0, 1, 8'h33, 3, 0, 8'h00);
        cyc4("st6", 1, 0, 0, 8'h00, 3, 1, 8'h11);
        cyc4("st7", 0, 0, 0, 8'h00, 3, 1, 8'h11);
        cyc4("st8", 1, 0, 0, 8'h00, 2, 1, 8'h22);
        cyc4("st9", 1, 0, 0, 8'h00, 1, 1, 8'h33);
        cyc4("st10", 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // Fill, then flush with en=1: flags cleared, data still shifts
        do_reset();
        cyc4("fl1", 1, 0, 1, 8'h01, 1, 0, 8'h00);
        cyc4("fl2", 1, 0, 1, 8'h02, 2, 0, 8'h00);
        cyc4("fl3", 1, 0, 1, 8'h03, 3, 0, 8'h00);
        cyc4("fl4", 1, 0, 1, 8'h04, 4, 1, 8'h01);
        cyc4("fl5", 1, 1, 1, 8'h05, 0, 0, 8'h00);
        check("fl_data_shift", 32'(out4), 32'h02);
        for (int i = 0; i < 5; i++) cyc4("fl_drain", 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // Flush with en=0: flags cleared, data holds
        cyc4("fh1", 1, 0, 1, 8'h0a, 1, 0, 8'h00);
        cyc4("fh2", 1, 0, 1, 8'h0b, 2, 0, 8'h00);
        cyc4("fh3", 1, 0, 1, 8'h0c, 3, 0, 8'h00);
        cyc4("fh4", 1, 0, 1, 8'h0d, 4, 1, 8'h0a);
        cyc4("fh5", 0, 1, 1, 8'h0e, 0, 0, 8'h00);
        check("fh_data_hold", 32'(out4), 32'h0a);

        // Reset mid-stream discards in-flight items and beats flush/en
        do_reset();
        cyc4("rs1", 1, 0, 1, 8'h21, 1, 0, 8'h00);
        cyc4("rs2", 1, 0, 1, 8'h22, 2, 0, 8'h00);
        cyc4("rs3", 1, 0, 1, 8'h23, 3, 0, 8'h00);
        rst = 1'b1;
        cyc4("rs4", 1, 1, 1, 8'h24, 0, 0, 8'h00);
`ifdef DFF_PIPE_RESET_DATA_EN
        check("rs_data_zero", 32'(out4), 32'h00);
`endif
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc4("rs_after", 1, 0, 0, 8'h00, 0, 0, 8'h00);

        // WIDTH=1, DEPTH=1: out follows in one cycle late, holds when en=0
        do_reset();
        en = 1'b1; in_valid = 1'b1;
        in1 = 1'b0; step();
        check("d1_a_out", 32'(out1), 0); check("d1_a_ov", 32'(ov1), 1); check("d1_a_cnt", 32'(cnt1), 1);
        in1 = 1'b1; step();
        check("d1_b_out", 32'(out1), 1);
        in1 = 1'b0; step();
        check("d1_c_out", 32'(out1), 0);
        en = 1'b0; in1 = 1'b1; step();
        check("d1_hold_out", 32'(out1), 0); check("d1_hold_ov", 32'(ov1), 1);
        step();
        check("d1_hold2_out", 32'(out1), 0);
        en = 1'b1; in_valid = 1'b0; in1 = 1'b1; step();
        check("d1_inv_ov", 32'(ov1), 0); check("d1_inv_cnt", 32'(cnt1), 0);
        check("d1_inv_data", 32'(out1), 1);

        // DEPTH=3: continuous valid input, count saturates at 3
        do_reset();
        en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in = 8'(i + 1);
            step();
            check($sformatf("d3_cnt%0d", i), 32'(cnt3), (i < 2) ? i + 1 : 3);
            check($sformatf("d3_ov%0d", i), 32'(ov3), (i >= 2) ? 1 : 0);
            if (i >= 2) check($sformatf("d3_out%0d", i), 32'(out3), i - 1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("d3_drain%0d", i), 32'(cnt3), 2 - i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
